// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, fetches over imem req/ack and presents instr/pcplus4 to decode (valid/ready).
// Latency: ack on the first REQ cycle gives instr_valid one cycle later; accept gives imem_req one cycle later.
// Backpressure: imem_req/imem_addr held until imem_ack; instr/pcplus4 held while instr_ready=0.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch_cnt/stall_cnt outputs.
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pcplus4,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             pcsrc,
    input  logic             jump,
    input  logic [WIDTH-1:0] pcbranch
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pcplus4_q, pcplus4_d;
    logic [WIDTH-1:0] next_pc;

    // Branch targets are word aligned, so the two low bits of pcbranch never matter.
    logic unused_pcbranch_lo;
    assign unused_pcbranch_lo = ^pcbranch[1:0];

    // Redirect select for the instruction being accepted; jump beats branch.
    always_comb begin
        next_pc = pcplus4_q;
        if (jump) begin
            next_pc = {pcplus4_q[WIDTH-1:28], instr_q[25:0], 2'b00};
        end else if (pcsrc) begin
            next_pc = {pcbranch[WIDTH-1:2], 2'b00};
        end
    end

    // State, PC and the presented instruction; reset abandons any open request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            pcplus4_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
        end
    end

    // Next state and handshake outputs; ack outside REQ is ignored.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pcplus4_d   = pcplus4_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d   = imem_rdata;
                    pcplus4_d = pc_q + PC_STEP;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    pc_d    = next_pc;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign pcplus4   = pcplus4_q;

`ifdef FETCH_PERF_CNT_EN
    logic        accept_w;
    logic        stall_w;
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    assign accept_w = (state_q == HOLD) && instr_ready;
    assign stall_w  = (state_q == REQ) && !imem_ack;

    // Saturating event counters: accepted instructions and REQ cycles spent waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept_w && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (stall_w && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios then randomized traffic against a transaction-level fetch model.
// Latency: outputs compared on every falling edge; inputs for the next rising edge chosen right after.
// Backpressure: decode readiness and memory ack delay are driven by per-phase policies.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        pcsrc;
    logic        jump;
    logic [31:0] pcbranch;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    fetch_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .pcplus4     (pcplus4),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .pcbranch    (pcbranch)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: where the fetcher is in its transaction, not how it encodes it.
    bit          m_req;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcp4;
    int          wait_cnt;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] m_fetch;
    logic [31:0] m_stall;
`endif

    // Stimulus policy.
    bit          rst_drv;
    int          pol_ready;      // 0/1 fixed, 2 random
    int          pol_ack_delay;  // REQ cycles without ack before ack; <0 random
    bit          pol_stray;      // ack value driven outside REQ
    bit          pol_redir_rand;
    logic        d_jump;
    logic        d_pcsrc;
    logic [31:0] d_pcbranch;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'b0, act}, {31'b0, exp});
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h4) return 32'h0800_0010;
        return addr ^ 32'hA5C3_1E77;
    endfunction

    task automatic model_reset();
        m_req    = 1'b0;
        m_valid  = 1'b0;
        m_pc     = 32'h0;
        m_instr  = 32'h0;
        m_pcp4   = 32'h0;
        wait_cnt = 0;
`ifdef FETCH_PERF_CNT_EN
        m_fetch  = 32'h0;
        m_stall  = 32'h0;
`endif
    endtask

    // One cycle: compare at the falling edge, then drive inputs and advance the model.
    task automatic step();
        logic a;
        @(negedge clk);
        chk1("imem_req", imem_req, m_req);
        chk("imem_addr", imem_addr, m_pc);
        chk1("instr_valid", instr_valid, m_valid);
        chk("instr", instr, m_instr);
        chk("pcplus4", pcplus4, m_pcp4);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, m_fetch);
        chk("stall_cnt", stall_cnt, m_stall);
`endif
        reset = rst_drv;
        if (m_req) begin
            if (pol_ack_delay < 0) a = ($urandom_range(0, 2) == 0);
            else                   a = (wait_cnt >= pol_ack_delay);
        end else begin
            if (pol_ack_delay < 0) a = 1'($urandom_range(0, 1));
            else                   a = pol_stray;
        end
        imem_ack   = a;
        imem_rdata = (pol_ack_delay < 0 || !(a && m_req)) ? $urandom : mem_word(m_pc);
        instr_ready = (pol_ready == 2) ? 1'($urandom_range(0, 1)) : (pol_ready != 0);
        if (pol_redir_rand) begin
            jump     = ($urandom_range(0, 3) == 0);
            pcsrc    = ($urandom_range(0, 2) == 0);
            pcbranch = $urandom;
        end else begin
            jump     = d_jump;
            pcsrc    = d_pcsrc;
            pcbranch = d_pcbranch;
        end
        if (!rst_drv) begin
            model_reset();
        end else if (!m_req && !m_valid) begin
            m_req = 1'b1;
        end else if (m_req) begin
            if (a) begin
                m_instr  = imem_rdata;
                m_pcp4   = m_pc + 32'd4;
                m_req    = 1'b0;
                m_valid  = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
`ifdef FETCH_PERF_CNT_EN
                if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
            end
        end else if (instr_ready) begin
`ifdef FETCH_PERF_CNT_EN
            if (m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 32'd1;
`endif
            if (jump)       m_pc = {m_pcp4[31:28], m_instr[25:0], 2'b00};
            else if (pcsrc) m_pc = {pcbranch[31:2], 2'b00};
            else            m_pc = m_pcp4;
            m_valid = 1'b0;
            m_req   = 1'b1;
        end
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        step();
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        chk1(nm, imem_req, 1'b1);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        step();
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        chk1(nm, instr_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  reqbits;
        logic [31:0] aq[$];
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        pcsrc = 1'b0; jump = 1'b0; pcbranch = '0;
        rst_drv = 1'b0; pol_ready = 1; pol_ack_delay = 0; pol_stray = 1'b0;
        pol_redir_rand = 1'b0; d_jump = 1'b0; d_pcsrc = 1'b0; d_pcbranch = '0;
        model_reset();

        // Reset state.
        step(); step();
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pcplus4", pcplus4, 32'h0);

        // Sequential fetch with immediate ack and ready decode.
        rst_drv = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            reqbits[3-i] = imem_req;
            if (imem_req) aq.push_back(imem_addr);
        end
        chk("t1_req_pattern", {28'b0, reqbits}, 32'h0000_000A);
        chk("t1_addr_count", 32'(aq.size()), 32'd2);
        chk("t1_addr0", aq[0], 32'h0);
        chk("t1_addr1", aq[1], 32'h4);
        chk("t1_model_pc", m_pc, 32'h8);

        // Ack delayed three cycles: address held for four REQ cycles.
        pol_ack_delay = 3;
        for (int i = 0; i < 4; i++) begin
            step();
            chk1("t2_req_held", imem_req, 1'b1);
            chk("t2_addr_held", imem_addr, 32'h8);
        end
        pol_ack_delay = 0;

        // Branch on accept: low target bits cleared.
        d_pcsrc = 1'b1; d_pcbranch = 32'h0000_0103;
        step();
        chk1("t4_valid", instr_valid, 1'b1);
        chk("t4_instr", instr, mem_word(32'h8));
        chk("t4_pcplus4", pcplus4, 32'hC);
`ifdef FETCH_PERF_CNT_EN
        chk("t2_stall_cnt", stall_cnt, 32'd3);
        chk("t1_fetch_cnt", fetch_cnt, 32'd2);
`endif
        step();
        chk("t4_branch_addr", imem_addr, 32'h100);

        // No accept: branch request is ignored and instr holds.
        pol_ready = 0; d_pcbranch = 32'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("t4_hold_valid", instr_valid, 1'b1);
            chk("t4_hold_instr", instr, mem_word(32'h100));
            chk("t4_hold_pc", imem_addr, 32'h100);
        end
        pol_ready = 1; d_pcbranch = 32'h4;
        wait_req("t3_req_to_4");
        chk("t3_addr4", imem_addr, 32'h4);

        // Jump with branch also asserted: jump wins.
        d_jump = 1'b1; d_pcsrc = 1'b1; d_pcbranch = 32'h200;
        wait_valid("t3_valid");
        chk("t3_instr", instr, 32'h0800_0010);
        chk("t3_pcplus4", pcplus4, 32'h8);
        wait_req("t3_req_jump");
        chk("t3_jump_addr", imem_addr, 32'h40);

        // PC wraps modulo 2^32.
        d_jump = 1'b0; d_pcsrc = 1'b1; d_pcbranch = 32'hFFFF_FFFF;
        wait_valid("t5_valid0");
        wait_req("t5_req_top");
        chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        d_pcsrc = 1'b0;
        wait_valid("t5_valid1");
        chk("t5_pcplus4_wrap", pcplus4, 32'h0);
        pol_ack_delay = 100;
        wait_req("t5_req_wrap");
        chk("t5_addr_wrap", imem_addr, 32'h0);

        // Asynchronous reset while a request is outstanding.
        step();
        #2;
        rst_drv = 1'b0;
        reset   = 1'b0;
        #1;
        chk1("t6_async_req", imem_req, 1'b0);
        chk1("t6_async_valid", instr_valid, 1'b0);
        model_reset();
        pol_stray = 1'b1;
        step(); step();
        pol_ack_delay = 0;
        rst_drv = 1'b1;
        step();
        step();
        chk1("t6_refetch_req", imem_req, 1'b1);
        chk("t6_refetch_addr", imem_addr, 32'h0);
        step();
        chk("t6_refetch_instr", instr, mem_word(32'h0));
        pol_stray = 1'b0;

        // Randomized traffic with occasional resets.
        pol_ack_delay = -1; pol_ready = 2; pol_redir_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst_drv = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
